// File: rtl/bsg_vanilla_simd_wb_sequencer.sv
// ============================================================================
// Module      : bsg_vanilla_simd_wb_sequencer
// Description : Buffers SIMD remote-load responses and serialises each lane
//               into single-word regfile writes (lane k -> rd+k).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bsg_vanilla_simd_wb_sequencer #(
   parameter int LANES_P           = 4,
   parameter int DATA_WIDTH_P      = 32,
   parameter int REG_ADDR_WIDTH_P  = 5,
   parameter int ELS_P             = 2,
   localparam int LANE_CNT_WIDTH_LP = $clog2(LANES_P + 1)
) (
   input  logic                              clk_i,
   input  logic                              reset_i,

   input  logic                              resp_v_i,
   output logic                              resp_ready_o,
   input  logic                              resp_float_i,
   input  logic [REG_ADDR_WIDTH_P-1:0]       resp_rd_i,
   input  logic [LANE_CNT_WIDTH_LP-1:0]      resp_num_lanes_i,
   input  logic [LANES_P*DATA_WIDTH_P-1:0]   resp_data_i,

   output logic                              wb_v_o,
   output logic                              wb_float_o,
   output logic [REG_ADDR_WIDTH_P-1:0]       wb_addr_o,
   output logic [DATA_WIDTH_P-1:0]           wb_data_o,
   input  logic                              wb_yumi_i,

   output logic                              clear_sb_v_o,
   output logic                              clear_sb_float_o,
   output logic [REG_ADDR_WIDTH_P-1:0]       clear_sb_addr_o,
   output logic                              busy_o
);

   localparam int PTR_W = (ELS_P > 1) ? $clog2(ELS_P) : 1;
   localparam int CNT_W = $clog2(ELS_P + 1);
   localparam int LCW   = LANE_CNT_WIDTH_LP;
   localparam int AW    = REG_ADDR_WIDTH_P;
   localparam int DW    = DATA_WIDTH_P;

   logic                       float_mem [ELS_P];
   logic [AW-1:0]              rd_mem    [ELS_P];
   logic [LCW-1:0]             nl_mem    [ELS_P];
   logic [LANES_P*DW-1:0]      data_mem  [ELS_P];

   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [CNT_W-1:0]           count;
   logic [LCW-1:0]             lane_cnt;

   logic                       full;
   logic                       empty;
   logic                       enq;
   logic                       head_v;
   logic                       head_float;
   logic [AW-1:0]              head_rd;
   logic [LCW-1:0]             head_n;
   logic [LANES_P*DW-1:0]      head_data;
   logic [AW-1:0]              lane_addr;
   logic [DW-1:0]              lane_data;
   logic                       skip;
   logic                       req;
   logic                       lane_done;
   logic                       last;
   logic                       pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(ELS_P - 1)) ? '0 : p + 1'b1;
   endfunction

   // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
   assign full  = (count == CNT_W'(ELS_P));
   assign empty = (count == '0);
   assign enq   = resp_v_i & resp_ready_o;

   assign head_v     = !empty & !reset_i;
   assign head_float = float_mem[rd_ptr];
   assign head_rd    = rd_mem[rd_ptr];
   assign head_n     = (nl_mem[rd_ptr] == '0) ? LCW'(LANES_P) : nl_mem[rd_ptr];
   assign head_data  = data_mem[rd_ptr];
   assign lane_addr  = head_rd + AW'(lane_cnt);

   always_comb begin
      lane_data = '0;
      for (int k = 0; k < LANES_P; k++) begin
         if (lane_cnt == LCW'(k)) lane_data = head_data[k*DW +: DW];
      end
   end

   // Integer x0 lanes are dropped internally instead of being requested.
   assign skip      = head_v & !head_float & (lane_addr == '0);
   assign req       = head_v & !skip;
   assign lane_done = skip | (req & wb_yumi_i);
   assign last      = (lane_cnt == head_n - LCW'(1));
   assign pop       = lane_done & last;

   always_ff @(posedge clk_i) begin
      if (enq) begin
         float_mem[wr_ptr] <= resp_float_i;
         rd_mem[wr_ptr]    <= resp_rd_i;
         nl_mem[wr_ptr]    <= resp_num_lanes_i;
         data_mem[wr_ptr]  <= resp_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         lane_cnt <= '0;
      end else begin
         if (enq) wr_ptr <= next_ptr(wr_ptr);
         if (pop) begin
            rd_ptr   <= next_ptr(rd_ptr);
            lane_cnt <= '0;
         end else if (lane_done) begin
            lane_cnt <= lane_cnt + 1'b1;
         end
         case ({enq, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      resp_ready_o     = !full & !reset_i;
      wb_v_o           = req;
      wb_float_o       = head_v ? head_float : 1'b0;
      wb_addr_o        = head_v ? lane_addr  : '0;
      wb_data_o        = head_v ? lane_data  : '0;
      clear_sb_v_o     = pop;
      clear_sb_float_o = pop ? head_float : 1'b0;
      clear_sb_addr_o  = pop ? head_rd    : '0;
      busy_o           = head_v;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(resp_v_i && (resp_num_lanes_i > LCW'(LANES_P))))
            else $error("resp_num_lanes_i exceeds lane count");
         assert (!(wb_yumi_i && !wb_v_o))
            else $error("wb_yumi_i without wb_v_o");
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bsg_vanilla_simd_wb_sequencer.sv
// ============================================================================
// Module      : tb_bsg_vanilla_simd_wb_sequencer
// Description : Directed self-checking bench for the SIMD writeback sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_vanilla_simd_wb_sequencer;

   logic          clk_i;
   logic          reset_i;
   logic          resp_v_i;
   logic          resp_ready_o;
   logic          resp_float_i;
   logic [4:0]    resp_rd_i;
   logic [2:0]    resp_num_lanes_i;
   logic [127:0]  resp_data_i;
   logic          wb_v_o;
   logic          wb_float_o;
   logic [4:0]    wb_addr_o;
   logic [31:0]   wb_data_o;
   logic          wb_yumi_i;
   logic          clear_sb_v_o;
   logic          clear_sb_float_o;
   logic [4:0]    clear_sb_addr_o;
   logic          busy_o;
   logic          yumi_en;

   int tests;
   int fails;

   bsg_vanilla_simd_wb_sequencer dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .resp_v_i         (resp_v_i),
      .resp_ready_o     (resp_ready_o),
      .resp_float_i     (resp_float_i),
      .resp_rd_i        (resp_rd_i),
      .resp_num_lanes_i (resp_num_lanes_i),
      .resp_data_i      (resp_data_i),
      .wb_v_o           (wb_v_o),
      .wb_float_o       (wb_float_o),
      .wb_addr_o        (wb_addr_o),
      .wb_data_o        (wb_data_o),
      .wb_yumi_i        (wb_yumi_i),
      .clear_sb_v_o     (clear_sb_v_o),
      .clear_sb_float_o (clear_sb_float_o),
      .clear_sb_addr_o  (clear_sb_addr_o),
      .busy_o           (busy_o)
   );

   // The arbiter model only grants a presented request.
   assign wb_yumi_i = yumi_en & wb_v_o;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] pk(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
      return {d, c, b, a};
   endfunction

   task automatic nxt();
      @(negedge clk_i);
      #1;
   endtask

   task automatic exp_wb(input string tag, input logic [63:0] v, input logic [63:0] f,
                         input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] clr, input logic [63:0] ca);
      check({tag, "_v"}, 64'(wb_v_o), v);
      if (v != 0) begin
         check({tag, "_float"}, 64'(wb_float_o), f);
         check({tag, "_addr"},  64'(wb_addr_o),  a);
         check({tag, "_data"},  64'(wb_data_o),  d);
      end
      check({tag, "_clr"}, 64'(clear_sb_v_o), clr);
      if (clr != 0) begin
         check({tag, "_clr_addr"},  64'(clear_sb_addr_o),  ca);
         check({tag, "_clr_float"}, 64'(clear_sb_float_o), f);
      end
   endtask

   task automatic send(input string tag, input logic f, input logic [4:0] rd,
                       input logic [2:0] n, input logic [127:0] d);
      @(negedge clk_i);
      resp_v_i         = 1'b1;
      resp_float_i     = f;
      resp_rd_i        = rd;
      resp_num_lanes_i = n;
      resp_data_i      = d;
      #1;
      check({tag, "_ready"}, 64'(resp_ready_o), 1);
      @(posedge clk_i);
      #1;
      resp_v_i = 1'b0;
   endtask

   task automatic exp_idle(input string tag);
      check({tag, "_v"},    64'(wb_v_o),       0);
      check({tag, "_clr"},  64'(clear_sb_v_o), 0);
      check({tag, "_busy"}, 64'(busy_o),       0);
   endtask

   initial begin
      tests            = 0;
      fails            = 0;
      reset_i          = 1'b1;
      resp_v_i         = 1'b1;
      resp_float_i     = 1'b0;
      resp_rd_i        = 5'd3;
      resp_num_lanes_i = 3'd1;
      resp_data_i      = '0;
      yumi_en          = 1'b0;

      // Reset: nothing accepted, every output low.
      repeat (2) @(negedge clk_i);
      #1;
      check("rst_ready", 64'(resp_ready_o), 0);
      exp_idle("rst");
      @(negedge clk_i);
      resp_v_i = 1'b0;
      reset_i  = 1'b0;
      #1;
      check("rst_rel_ready", 64'(resp_ready_o), 1);
      exp_idle("rst_rel");

      // 1: FP rd=8, four lanes with continuous grants.
      yumi_en = 1'b1;
      send("t1", 1'b1, 5'd8, 3'd4, pk(32'hA, 32'hB, 32'hC, 32'hD));
      nxt(); exp_wb("t1_l0", 1, 1, 8,  32'hA, 0, 0);
      nxt(); exp_wb("t1_l1", 1, 1, 9,  32'hB, 0, 0);
      nxt(); exp_wb("t1_l2", 1, 1, 10, 32'hC, 0, 0);
      nxt(); exp_wb("t1_l3", 1, 1, 11, 32'hD, 1, 8);
      nxt(); exp_idle("t1_end");

      // 2: int rd=30 wraps through x0, which is skipped.
      send("t2", 1'b0, 5'd30, 3'd4, pk(1, 2, 3, 4));
      nxt(); exp_wb("t2_l0", 1, 0, 30, 1, 0, 0);
      nxt(); exp_wb("t2_l1", 1, 0, 31, 2, 0, 0);
      nxt(); exp_wb("t2_x0", 0, 0, 0,  0, 0, 0);
      nxt(); exp_wb("t2_l3", 1, 0, 1,  4, 1, 30);
      nxt(); exp_idle("t2_end");

      // 3: stall lane 1 for five cycles.
      send("t3", 1'b1, 5'd4, 3'd4, pk(10, 11, 12, 13));
      nxt(); exp_wb("t3_l0", 1, 1, 4, 10, 0, 0);
      nxt(); exp_wb("t3_l1", 1, 1, 5, 11, 0, 0);
      yumi_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         nxt(); exp_wb("t3_stall", 1, 1, 5, 11, 0, 0);
         check("t3_stall_busy", 64'(busy_o), 1);
      end
      yumi_en = 1'b1;
      nxt(); exp_wb("t3_l2", 1, 1, 6, 12, 0, 0);
      nxt(); exp_wb("t3_l3", 1, 1, 7, 13, 1, 4);
      nxt(); exp_idle("t3_end");

      // 4: buffer fills at two entries; third enters after the first pop.
      yumi_en = 1'b0;
      @(negedge clk_i);
      resp_v_i = 1'b1; resp_float_i = 1'b0; resp_num_lanes_i = 3'd1;
      resp_rd_i = 5'd1; resp_data_i = pk(100, 0, 0, 0);
      #1; check("t4_r1_ready", 64'(resp_ready_o), 1);
      @(negedge clk_i);
      resp_rd_i = 5'd2; resp_data_i = pk(200, 0, 0, 0);
      #1; check("t4_r2_ready", 64'(resp_ready_o), 1);
      exp_wb("t4_head1", 1, 0, 1, 100, 0, 0);
      @(negedge clk_i);
      resp_rd_i = 5'd3; resp_data_i = pk(300, 0, 0, 0);
      #1; check("t4_full_ready", 64'(resp_ready_o), 0);
      nxt(); check("t4_full_ready2", 64'(resp_ready_o), 0);
      check("t4_busy", 64'(busy_o), 1);
      yumi_en = 1'b1;
      #1; check("t4_pop_ready", 64'(resp_ready_o), 0);
      exp_wb("t4_pop1", 1, 0, 1, 100, 1, 1);
      nxt(); check("t4_after_pop_ready", 64'(resp_ready_o), 1);
      exp_wb("t4_pop2", 1, 0, 2, 200, 1, 2);
      @(posedge clk_i);
      #1; resp_v_i = 1'b0;
      nxt(); exp_wb("t4_pop3", 1, 0, 3, 300, 1, 3);
      nxt(); exp_idle("t4_end");

      // 5: single lane to f0, then n=0 meaning all lanes.
      send("t5a", 1'b1, 5'd0, 3'd1, pk(32'h55, 0, 0, 0));
      nxt(); exp_wb("t5a_f0", 1, 1, 0, 32'h55, 1, 0);
      nxt(); exp_idle("t5a_end");
      send("t5b", 1'b0, 5'd12, 3'd0, pk(21, 22, 23, 24));
      nxt(); exp_wb("t5b_l0", 1, 0, 12, 21, 0, 0);
      nxt(); exp_wb("t5b_l1", 1, 0, 13, 22, 0, 0);
      nxt(); exp_wb("t5b_l2", 1, 0, 14, 23, 0, 0);
      nxt(); exp_wb("t5b_l3", 1, 0, 15, 24, 1, 12);
      nxt(); exp_idle("t5b_end");

      // 6: reset during lane 2 drops the rest of the entry.
      send("t6", 1'b0, 5'd20, 3'd4, pk(31, 32, 33, 34));
      nxt(); exp_wb("t6_l0", 1, 0, 20, 31, 0, 0);
      nxt(); exp_wb("t6_l1", 1, 0, 21, 32, 0, 0);
      @(negedge clk_i);
      reset_i = 1'b1;
      #1;
      exp_idle("t6_rst");
      check("t6_rst_ready", 64'(resp_ready_o), 0);
      @(negedge clk_i);
      reset_i = 1'b0;
      #1;
      check("t6_rel_ready", 64'(resp_ready_o), 1);
      exp_idle("t6_rel");
      nxt(); exp_idle("t6_after");
      nxt(); exp_idle("t6_after2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
